stream_mux_n_to_1: RTL

//  Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshake.

---
 rtl/mux_pkg.sv | 19 +
 rtl/stream_mux_n_to_1_rr_arbiter.sv | 31 +++
 rtl/stream_mux_n_to_1.sv | 101 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types for the N-to-1 stream multiplexer: select mode, output register state
// and the wrap-around index step used by both the arbiter and the pointer update.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_n_to_1_rr_arbiter.sv
// Combinational round-robin find-first: returns the first requesting channel
// at or after Ptr, wrapping from N-1 back to 0.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    Req,
  input  logic [SELW-1:0] Ptr,
  output logic [SELW-1:0] Gnt,
  output logic            GntOk
);

  always_comb begin
    int idx;
    Gnt   = '0;
    GntOk = 1'b0;
    idx   = int'(Ptr);
    // An out-of-range pointer cannot occur in normal use; restart the scan at 0 if it does.
    if (idx >= N) idx = 0;
    for (int k = 0; k < N; k++) begin
      if (!GntOk && Req[idx]) begin
        GntOk = 1'b1;
        Gnt   = SELW'(idx);
      end
      idx = next_idx(idx, N);
    end
  end

endmodule

// File: rtl/stream_mux_n_to_1.sv
// N-channel registered stream multiplexer: one channel granted per cycle (fixed select
// or round-robin), the chosen word is held in a single output register with its channel.
module stream_mux_n_to_1
  import mux_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              Mode,
  input  logic [SELW-1:0]   Sel,
  input  logic [N-1:0]      InValid,
  input  logic [N*W-1:0]    InData,
  output logic [N-1:0]      InReady,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [W-1:0]      OutData,
  output logic [SELW-1:0]   OutChan,
  output out_state_e        DbgState,
  output logic [SELW-1:0]   DbgPtr
);

  // Handshake: a word moves on an edge where valid & ready are both high. Producers hold
  // valid/data until ready; InReady depends combinationally on the output register state.

  out_state_e      state;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_gnt;
  logic            rr_ok;
  logic [SELW-1:0] gnt;
  logic            gnt_ok;
  logic            gnt_valid;
  logic [W-1:0]    gnt_data;
  logic            space;
  logic            accept;
  mux_mode_e       mode;

  assign mode = mux_mode_e'(Mode);

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .Req   (InValid),
    .Ptr   (ptr),
    .Gnt   (rr_gnt),
    .GntOk (rr_ok)
  );

  always_comb begin
    if (mode == MODE_RR) begin
      gnt    = rr_gnt;
      gnt_ok = rr_ok;
    end else begin
      gnt    = Sel;
      gnt_ok = (int'(Sel) < N);
    end
  end

  assign space = (state == ST_EMPTY) || OutReady;

  // Decode by comparison so a select beyond N-1 simply matches no channel.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = '0;
    InReady   = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SELW'(i)) begin
        gnt_valid  = InValid[i];
        gnt_data   = InData[i*W +: W];
        InReady[i] = gnt_ok & space;
      end
    end
  end

  assign accept = gnt_ok & gnt_valid & space;

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state   <= ST_EMPTY;
      OutData <= '0;
      OutChan <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state <= ST_FULL;
        ST_FULL:  if (OutReady && !accept) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
      if (accept) begin
        OutData <= gnt_data;
        OutChan <= gnt;
        if (mode == MODE_RR) ptr <= SELW'(next_idx(int'(gnt), N));
      end
    end
  end

  assign OutValid = (state == ST_FULL);
  assign DbgState = state;
  assign DbgPtr   = ptr;

endmodule
